// File: rtl/hdmi_pkg.sv
// Shared TMDS symbol constants, raster region and pixel-lock types for the HDMI raster scheduler.
package hdmi_pkg;

   localparam int TMDS_SYM_W = 10;
   localparam int NUM_CH     = 3;

   localparam logic [TMDS_SYM_W-1:0] TMDS_CTL_00 = 10'b1101010100;
   localparam logic [TMDS_SYM_W-1:0] TMDS_CTL_01 = 10'b0010101011;
   localparam logic [TMDS_SYM_W-1:0] TMDS_CTL_10 = 10'b0101010100;
   localparam logic [TMDS_SYM_W-1:0] TMDS_CTL_11 = 10'b1010101011;
   localparam logic [TMDS_SYM_W-1:0] TMDS_NOOP   = TMDS_CTL_00;

   localparam logic [TMDS_SYM_W-1:0] TMDS_GB_CH0 = 10'b1011001100;
   localparam logic [TMDS_SYM_W-1:0] TMDS_GB_CH1 = 10'b0100110011;
   localparam logic [TMDS_SYM_W-1:0] TMDS_GB_CH2 = 10'b1011001100;

   typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} region_e;

   typedef enum logic {PIX_LOCKED, PIX_HUNT} pix_state_e;

   function automatic logic [TMDS_SYM_W-1:0] tmds_ctl(input logic c1, input logic c0);
      logic [TMDS_SYM_W-1:0] sym;
      sym = TMDS_CTL_00;
      case ({c1, c0})
         2'b01:   sym = TMDS_CTL_01;
         2'b10:   sym = TMDS_CTL_10;
         2'b11:   sym = TMDS_CTL_11;
         default: sym = TMDS_CTL_00;
      endcase
      return sym;
   endfunction

endpackage

// File: rtl/hdmi_raster_counter.sv
// Horizontal/vertical raster position counters with region decode and
// slot markers for the line-leading preamble and guard band.
module hdmi_raster_counter
   import hdmi_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
)(
   input  logic    clk_px,
   input  logic    resetn,
   input  logic    adv,
   output region_e h_region,
   output region_e v_region,
   output logic    first_pixel,
   output logic    next_line_active,
   output logic    preamble_slot,
   output logic    guard_slot
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   logic [HW-1:0] h;
   logic [VW-1:0] v;
   int            h_i;
   int            v_i;

   always_ff @(posedge clk_px) begin
      if (!resetn) begin
         h <= '0;
         v <= '0;
      end else if (adv) begin
         if (h == HW'(H_TOTAL - 1)) begin
            h <= '0;
            v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + VW'(1);
         end else begin
            h <= h + HW'(1);
         end
      end
   end

   assign h_i = int'(h);
   assign v_i = int'(v);

   always_comb begin
      h_region = BP;
      if (h_i < H_ACTIVE)                      h_region = ACTIVE;
      else if (h_i < H_ACTIVE + H_FP)          h_region = FP;
      else if (h_i < H_ACTIVE + H_FP + H_SYNC) h_region = SYNC;

      v_region = BP;
      if (v_i < V_ACTIVE)                      v_region = ACTIVE;
      else if (v_i < V_ACTIVE + V_FP)          v_region = FP;
      else if (v_i < V_ACTIVE + V_FP + V_SYNC) v_region = SYNC;
   end

   // Preamble and guard positions are the tail of back porch; the scheduler
   // qualifies them with next_line_active.
   assign first_pixel      = (h_i == 0) && (v_i == 0);
   assign next_line_active = (v_i == V_TOTAL - 1) || (v_i < V_ACTIVE - 1);
   assign preamble_slot    = (h_i >= H_TOTAL - 10) && (h_i <= H_TOTAL - 3);
   assign guard_slot       = (h_i >= H_TOTAL - 2);

endmodule

// File: rtl/hdmi_raster_sched.sv
// Raster scheduler emitting the per-pixel-clock TMDS command stream for the HDMI output stage.
// Define HDMI_VIDEO_GUARD_EN to add video preamble and guard-band symbols (HDMI mode); default is DVI.
module hdmi_raster_sched
   import hdmi_pkg::*;
#(
   parameter int          H_ACTIVE  = 640,
   parameter int          H_FP      = 16,
   parameter int          H_SYNC    = 96,
   parameter int          H_BP      = 48,
   parameter int          V_ACTIVE  = 480,
   parameter int          V_FP      = 10,
   parameter int          V_SYNC    = 2,
   parameter int          V_BP      = 33,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0,
   parameter logic [29:0] FILL_WORD = 30'h10040100
)(
   input  logic        clk_px,
   input  logic        resetn,
   input  logic [29:0] pix_tdata,
   input  logic        pix_tuser,
   input  logic        pix_tvalid,
   output logic        pix_tready,
   output logic [31:0] cmd_tdata,
   output logic        cmd_tvalid,
   input  logic        cmd_tready,
   output logic        frame_pulse,
   output logic        pix_err,
   input  logic        pix_err_clr
);

   region_e     h_region;
   region_e     v_region;
   logic        first_pixel;
   logic        next_line_active;
   logic        preamble_slot;
   logic        guard_slot;
   logic        guard_on;
   logic        load;
   logic        active_slot;
   logic        hs_lvl;
   logic        vs_lvl;
   logic        err_set;
   logic [29:0] blank_word;
   logic [29:0] slot_word;
   pix_state_e  state;
   pix_state_e  state_nxt;

`ifdef HDMI_VIDEO_GUARD_EN
   assign guard_on = 1'b1;
`else
   assign guard_on = 1'b0;
`endif

   assign load        = resetn && (!cmd_tvalid || cmd_tready);
   assign active_slot = (h_region == ACTIVE) && (v_region == ACTIVE);

   hdmi_raster_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_counter (
      .clk_px           (clk_px),
      .resetn           (resetn),
      .adv              (load),
      .h_region         (h_region),
      .v_region         (v_region),
      .first_pixel      (first_pixel),
      .next_line_active (next_line_active),
      .preamble_slot    (preamble_slot),
      .guard_slot       (guard_slot)
   );

   always_comb begin
      hs_lvl     = (h_region == SYNC) ? HSYNC_POL : ~HSYNC_POL;
      vs_lvl     = (v_region == SYNC) ? VSYNC_POL : ~VSYNC_POL;
      blank_word = {TMDS_CTL_00, TMDS_CTL_00, tmds_ctl(vs_lvl, hs_lvl)};
      if (guard_on && next_line_active && guard_slot)
         blank_word = {TMDS_GB_CH2, TMDS_GB_CH1, TMDS_GB_CH0};
      else if (guard_on && next_line_active && preamble_slot)
         blank_word = {TMDS_CTL_00, TMDS_CTL_01, tmds_ctl(vs_lvl, hs_lvl)};
   end

   // While hunting, untagged pixels drain in any slot; a tagged pixel waits
   // for slot (0,0) so the first frame after relock starts aligned.
   always_comb begin
      slot_word  = blank_word;
      state_nxt  = state;
      err_set    = 1'b0;
      pix_tready = 1'b0;
      if (state == PIX_HUNT) begin
         pix_tready = pix_tvalid && !pix_tuser;
         if (active_slot)
            slot_word = FILL_WORD;
         if (load && first_pixel && pix_tvalid && pix_tuser) begin
            pix_tready = 1'b1;
            slot_word  = pix_tdata;
            state_nxt  = PIX_LOCKED;
         end
      end else if (active_slot) begin
         if (!pix_tvalid) begin
            slot_word = FILL_WORD;
            err_set   = load;
            state_nxt = load ? PIX_HUNT : state;
         end else if (first_pixel && !pix_tuser) begin
            slot_word  = FILL_WORD;
            pix_tready = load;
            err_set    = load;
            state_nxt  = load ? PIX_HUNT : state;
         end else begin
            slot_word  = pix_tdata;
            pix_tready = load;
         end
      end
      if (!resetn)
         pix_tready = 1'b0;
   end

   always_ff @(posedge clk_px) begin
      if (!resetn)
         state <= PIX_HUNT;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk_px) begin
      if (!resetn) begin
         cmd_tvalid  <= 1'b0;
         cmd_tdata   <= {2'b00, TMDS_NOOP, TMDS_NOOP, TMDS_NOOP};
         frame_pulse <= 1'b0;
         pix_err     <= 1'b0;
      end else begin
         frame_pulse <= load && first_pixel;
         if (load) begin
            cmd_tvalid <= 1'b1;
            cmd_tdata  <= {2'b00, slot_word};
         end
         if (err_set)
            pix_err <= 1'b1;
         else if (pix_err_clr)
            pix_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hdmi_raster_sched.sv
// Scoreboard bench for hdmi_raster_sched on a 20x5 raster: expected command words are queued
// per frame up front and a negedge monitor compares every word the DUT hands downstream.
module tb_hdmi_raster_sched;

   localparam int H_ACT = 4, H_FPW = 2, H_SYW = 2, H_BPW = 12;
   localparam int V_ACT = 2, V_FPW = 1, V_SYW = 1, V_BPW = 1;
   localparam int FRAME_SLOTS = 100;
   localparam int NUM_FRAMES  = 7;
   localparam int TOTAL_SLOTS = FRAME_SLOTS * NUM_FRAMES;
   localparam logic [29:0] FILL      = 30'h10040100;
   localparam logic [31:0] NOOP_WORD = {2'b00, 10'h354, 10'h354, 10'h354};

   typedef struct {
      logic        bubble;
      logic        tuser;
      logic [29:0] data;
   } pix_t;

   logic        clk_px = 1'b0;
   logic        resetn;
   logic [29:0] pix_tdata;
   logic        pix_tuser;
   logic        pix_tvalid;
   logic        pix_tready;
   logic [31:0] cmd_tdata;
   logic        cmd_tvalid;
   logic        cmd_tready;
   logic        frame_pulse;
   logic        pix_err;
   logic        pix_err_clr;

   logic [31:0] exp_q[$];
   pix_t        pix_q[$];
   logic [29:0] act_words[8];
   logic [31:0] mon_exp;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          slot_cnt = 0;

   hdmi_raster_sched #(
      .H_ACTIVE  (H_ACT),
      .H_FP      (H_FPW),
      .H_SYNC    (H_SYW),
      .H_BP      (H_BPW),
      .V_ACTIVE  (V_ACT),
      .V_FP      (V_FPW),
      .V_SYNC    (V_SYW),
      .V_BP      (V_BPW),
      .HSYNC_POL (1'b0),
      .VSYNC_POL (1'b0),
      .FILL_WORD (FILL)
   ) dut (
      .clk_px      (clk_px),
      .resetn      (resetn),
      .pix_tdata   (pix_tdata),
      .pix_tuser   (pix_tuser),
      .pix_tvalid  (pix_tvalid),
      .pix_tready  (pix_tready),
      .cmd_tdata   (cmd_tdata),
      .cmd_tvalid  (cmd_tvalid),
      .cmd_tready  (cmd_tready),
      .frame_pulse (frame_pulse),
      .pix_err     (pix_err),
      .pix_err_clr (pix_err_clr)
   );

   always #5 clk_px = ~clk_px;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual === expected)
         n_pass++;
      else
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic bubble, input logic tuser, input logic [29:0] data);
      pix_t e;
      e.bubble = bubble;
      e.tuser  = tuser;
      e.data   = data;
      pix_q.push_back(e);
   endtask

   function automatic logic [29:0] pix_val(input int f, input int i);
      return 30'(f * 4096 + i * 16 + 5);
   endfunction

   // Hand-written raster map: h 0-3 active, 6-7 hsync, v 3 vsync, both active-low.
   function automatic logic [29:0] blank_word(input int h, input int v);
      logic       hs;
      logic       vs;
      logic [9:0] c0;
      logic [29:0] w;
      hs = !(h == 6 || h == 7);
      vs = !(v == 3);
      case ({vs, hs})
         2'b00:   c0 = 10'h354;
         2'b01:   c0 = 10'h0AB;
         2'b10:   c0 = 10'h154;
         default: c0 = 10'h2AB;
      endcase
      w = {10'h354, 10'h354, c0};
`ifdef HDMI_VIDEO_GUARD_EN
      if (v == 4 || v == 0) begin
         if (h >= 10 && h <= 17)
            w = {10'h354, 10'h0AB, c0};
         else if (h >= 18)
            w = {10'h2CC, 10'h133, 10'h2CC};
      end
`endif
      return w;
   endfunction

   task automatic expect_frame();
      for (int v = 0; v < 5; v++) begin
         for (int h = 0; h < 20; h++) begin
            if (v < V_ACT && h < H_ACT)
               exp_q.push_back({2'b00, act_words[v * H_ACT + h]});
            else
               exp_q.push_back({2'b00, blank_word(h, v)});
         end
      end
   endtask

   task automatic wait_slots(input int n);
      int guard = 0;
      while (slot_cnt < n && guard < 4000) begin
         @(posedge clk_px);
         guard++;
      end
      #1;
      if (slot_cnt < n) begin
         n_checks++;
         $display("[TB] FAIL wait_slots: reached %0d, needed %0d", slot_cnt, n);
      end
   endtask

   // Pixel source: presents the queue head; a bubble entry withholds valid for one loaded slot.
   initial begin
      logic take;
      pix_tvalid = 1'b0;
      pix_tdata  = '0;
      pix_tuser  = 1'b0;
      forever begin
         @(negedge clk_px);
         if (pix_q.size() > 0 && pix_q[0].bubble)
            take = resetn && cmd_tready;
         else
            take = pix_tvalid && pix_tready;
         @(posedge clk_px);
         #1;
         if (take && pix_q.size() > 0)
            pix_q.delete(0);
         if (pix_q.size() > 0 && !pix_q[0].bubble) begin
            pix_tvalid = 1'b1;
            pix_tdata  = pix_q[0].data;
            pix_tuser  = pix_q[0].tuser;
         end else begin
            pix_tvalid = 1'b0;
            pix_tdata  = '0;
            pix_tuser  = 1'b0;
         end
      end
   end

   // Monitor: every word taken downstream is matched against the scoreboard in order.
   always @(negedge clk_px) begin
      if (resetn && cmd_tvalid && cmd_tready) begin
         if (slot_cnt < TOTAL_SLOTS) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("[TB] FAIL scoreboard_empty: slot %0d got %h, expected none", slot_cnt, cmd_tdata);
            end else begin
               mon_exp = exp_q.pop_front();
               checkOutput($sformatf("cmd_tdata slot %0d", slot_cnt), cmd_tdata, mon_exp);
            end
            checkOutput($sformatf("frame_pulse slot %0d", slot_cnt), 32'(frame_pulse),
                        32'((slot_cnt % FRAME_SLOTS) == 0));
         end
         slot_cnt++;
      end
   end

   initial begin
      resetn      = 1'b0;
      cmd_tready  = 1'b1;
      pix_err_clr = 1'b0;

      for (int i = 0; i < 8; i++) act_words[i] = FILL;
      expect_frame();
      for (int i = 0; i < 8; i++) act_words[i] = pix_val(2, i);
      expect_frame();
      for (int i = 0; i < 8; i++) act_words[i] = (i < 2) ? pix_val(3, i) : FILL;
      expect_frame();
      for (int i = 0; i < 8; i++) act_words[i] = pix_val(4, i);
      expect_frame();
      for (int i = 0; i < 8; i++) act_words[i] = FILL;
      expect_frame();
      for (int i = 0; i < 8; i++) act_words[i] = pix_val(6, i);
      expect_frame();
      for (int i = 0; i < 8; i++) act_words[i] = pix_val(7, i);
      expect_frame();

      repeat (3) @(posedge clk_px);
      @(negedge clk_px);
      checkOutput("reset_cmd_tvalid", 32'(cmd_tvalid), 32'd0);
      checkOutput("reset_cmd_tdata", cmd_tdata, NOOP_WORD);
      checkOutput("reset_pix_tready", 32'(pix_tready), 32'd0);
      checkOutput("reset_frame_pulse", 32'(frame_pulse), 32'd0);
      checkOutput("reset_pix_err", 32'(pix_err), 32'd0);

      @(posedge clk_px);
      #1 resetn = 1'b1;
      @(negedge clk_px);
      checkOutput("release_cycle0_tvalid", 32'(cmd_tvalid), 32'd0);
      checkOutput("release_cycle0_tdata", cmd_tdata, NOOP_WORD);

      @(posedge clk_px);
      #1;
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, i == 0, pix_val(2, i));
      applyStimulus(1'b0, 1'b1, pix_val(3, 0));
      applyStimulus(1'b0, 1'b0, pix_val(3, 1));
      applyStimulus(1'b1, 1'b0, '0);
      for (int i = 2; i < 8; i++) applyStimulus(1'b0, 1'b0, pix_val(3, i));
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, i == 0, pix_val(4, i));
      applyStimulus(1'b0, 1'b0, 30'h0ABCDEF);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, i == 0, pix_val(6, i));
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, i == 0, pix_val(7, i));
      @(negedge clk_px);
      checkOutput("release_cycle1_tvalid", 32'(cmd_tvalid), 32'd1);

      wait_slots(90);
      checkOutput("hunt_frame_no_err", 32'(pix_err), 32'd0);
      wait_slots(190);
      checkOutput("clean_frame_no_err", 32'(pix_err), 32'd0);
      wait_slots(250);
      checkOutput("underflow_err_set", 32'(pix_err), 32'd1);
      wait_slots(350);
      checkOutput("err_sticky", 32'(pix_err), 32'd1);
      pix_err_clr = 1'b1;
      @(posedge clk_px);
      #1 pix_err_clr = 1'b0;
      wait_slots(390);
      checkOutput("err_cleared", 32'(pix_err), 32'd0);
      wait_slots(450);
      checkOutput("misalign_err_set", 32'(pix_err), 32'd1);
      pix_err_clr = 1'b1;
      @(posedge clk_px);
      #1 pix_err_clr = 1'b0;
      wait_slots(550);
      checkOutput("relock_no_err", 32'(pix_err), 32'd0);

      wait_slots(602);
      cmd_tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_px);
         checkOutput($sformatf("stall_pix_tready %0d", i), 32'(pix_tready), 32'd0);
         checkOutput($sformatf("stall_cmd_hold %0d", i), cmd_tdata, exp_q[0]);
      end
      @(posedge clk_px);
      #1 cmd_tready = 1'b1;

      wait_slots(690);
      checkOutput("backpressure_no_err", 32'(pix_err), 32'd0);
      wait_slots(TOTAL_SLOTS);
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      wait_slots(710);
      resetn = 1'b0;
      @(posedge clk_px);
      @(negedge clk_px);
      checkOutput("midframe_reset_tvalid", 32'(cmd_tvalid), 32'd0);
      checkOutput("midframe_reset_tdata", cmd_tdata, NOOP_WORD);
      checkOutput("midframe_reset_frame_pulse", 32'(frame_pulse), 32'd0);
      checkOutput("midframe_reset_pix_err", 32'(pix_err), 32'd0);
      checkOutput("midframe_reset_pix_tready", 32'(pix_tready), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
